// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared register-file widths, zero-register index and datapath typedefs
package reg_file_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS = 32;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: combinational read mux with zero-register forcing and optional write bypass
module reg_file_read_port #(
  parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_file_pkg::REG_ADDR_WIDTH,
  parameter bit WRITE_BYPASS = 1'b0
) (
  input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] data
);
  import reg_file_pkg::*;
  logic hit;
  assign hit = WRITE_BYPASS && write_en && !reset && addr == write_reg;
  assign data = (addr == ADDR_WIDTH'(ZERO_REG)) ? '0 : hit ? write_data : regs[addr];
endmodule

// File: rtl/reg_file.sv
// reg_file: 32x32 MIPS register file, two async read ports, one sync write port, r0 hardwired to zero
module reg_file #(
  parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_file_pkg::REG_ADDR_WIDTH,
  parameter bit WRITE_BYPASS = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  input  logic [ADDR_WIDTH-1:0] read_reg_1,
  input  logic [ADDR_WIDTH-1:0] read_reg_2,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data
);
  import reg_file_pkg::*;
  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (reset) regs <= '{default: '0};
    else if (write_en && write_reg != ADDR_WIDTH'(ZERO_REG)) regs[write_reg] <= write_data;
  end
  reg_file_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .WRITE_BYPASS(WRITE_BYPASS)) port_1 (
    .regs(regs), .addr(read_reg_1), .reset(reset), .write_en(write_en),
    .write_reg(write_reg), .write_data(write_data), .data(read_data_1)
  );
  reg_file_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .WRITE_BYPASS(WRITE_BYPASS)) port_2 (
    .regs(regs), .addr(read_reg_2), .reset(reset), .write_en(write_en),
    .write_reg(write_reg), .write_data(write_data), .data(read_data_2)
  );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed checks of reg_file with and without write bypass, driven in lockstep
module tb_reg_file;
  logic clk = 0;
  logic reset = 1;
  logic [4:0] rr1 = 0, rr2 = 0, wr = 0;
  logic we = 0;
  logic [31:0] wd = 0;
  logic [31:0] a1, a2, b1, b2;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  reg_file #(.WRITE_BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .read_data_1(a1), .read_data_2(a2),
    .read_reg_1(rr1), .read_reg_2(rr2), .write_en(we), .write_reg(wr), .write_data(wd)
  );
  reg_file #(.WRITE_BYPASS(1'b1)) dut_bp (
    .clk(clk), .reset(reset), .read_data_1(b1), .read_data_2(b2),
    .read_reg_1(rr1), .read_reg_2(rr2), .write_en(we), .write_reg(wr), .write_data(wd)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic write(input logic [4:0] r, input logic [31:0] d);
    we = 1; wr = r; wd = d;
    tick();
    we = 0;
  endtask
  task automatic test_reset();
    reset = 1; we = 0; rr1 = 15; rr2 = 31;
    tick();
    reset = 0;
    #1;
    checks++; if (a1 !== 32'h0) begin fails++; $display("FAIL reset_nb_1 got %h want %h", a1, 32'h0); end
    checks++; if (a2 !== 32'h0) begin fails++; $display("FAIL reset_nb_2 got %h want %h", a2, 32'h0); end
    checks++; if (b1 !== 32'h0) begin fails++; $display("FAIL reset_bp_1 got %h want %h", b1, 32'h0); end
    checks++; if (b2 !== 32'h0) begin fails++; $display("FAIL reset_bp_2 got %h want %h", b2, 32'h0); end
  endtask
  task automatic test_basic_write();
    write(10, 32'h1234ABCD);
    rr1 = 10; rr2 = 15;
    #1;
    checks++; if (a1 !== 32'h1234ABCD) begin fails++; $display("FAIL basic_nb_1 got %h want %h", a1, 32'h1234ABCD); end
    checks++; if (a2 !== 32'h0) begin fails++; $display("FAIL basic_nb_2 got %h want %h", a2, 32'h0); end
    checks++; if (b1 !== 32'h1234ABCD) begin fails++; $display("FAIL basic_bp_1 got %h want %h", b1, 32'h1234ABCD); end
    checks++; if (b2 !== 32'h0) begin fails++; $display("FAIL basic_bp_2 got %h want %h", b2, 32'h0); end
  endtask
  task automatic test_zero_reg();
    we = 1; wr = 0; wd = 32'hFFFFFFFF; rr1 = 0; rr2 = 0;
    #1;
    checks++; if (a1 !== 32'h0) begin fails++; $display("FAIL zero_pre_nb got %h want %h", a1, 32'h0); end
    checks++; if (b1 !== 32'h0) begin fails++; $display("FAIL zero_pre_bp got %h want %h", b1, 32'h0); end
    tick();
    we = 0;
    #1;
    checks++; if (a1 !== 32'h0) begin fails++; $display("FAIL zero_post_nb got %h want %h", a1, 32'h0); end
    checks++; if (b2 !== 32'h0) begin fails++; $display("FAIL zero_post_bp got %h want %h", b2, 32'h0); end
  endtask
  task automatic test_write_disable();
    we = 0; wr = 5; wd = 32'hDEADBEEF; rr1 = 5; rr2 = 5;
    tick();
    checks++; if (a1 !== 32'h0) begin fails++; $display("FAIL wdis_nb got %h want %h", a1, 32'h0); end
    checks++; if (b1 !== 32'h0) begin fails++; $display("FAIL wdis_bp got %h want %h", b1, 32'h0); end
    write(5, 32'hDEADBEEF);
    checks++; if (a1 !== 32'hDEADBEEF) begin fails++; $display("FAIL wen_nb_1 got %h want %h", a1, 32'hDEADBEEF); end
    checks++; if (a2 !== 32'hDEADBEEF) begin fails++; $display("FAIL wen_nb_2 got %h want %h", a2, 32'hDEADBEEF); end
    checks++; if (b1 !== 32'hDEADBEEF) begin fails++; $display("FAIL wen_bp_1 got %h want %h", b1, 32'hDEADBEEF); end
    checks++; if (b2 !== 32'hDEADBEEF) begin fails++; $display("FAIL wen_bp_2 got %h want %h", b2, 32'hDEADBEEF); end
  endtask
  task automatic test_hazard();
    write(7, 32'h11111111);
    we = 1; wr = 7; wd = 32'h22222222; rr1 = 7; rr2 = 10;
    #1;
    checks++; if (a1 !== 32'h11111111) begin fails++; $display("FAIL hazard_pre_nb got %h want %h", a1, 32'h11111111); end
    checks++; if (b1 !== 32'h22222222) begin fails++; $display("FAIL hazard_pre_bp got %h want %h", b1, 32'h22222222); end
    checks++; if (b2 !== 32'h1234ABCD) begin fails++; $display("FAIL hazard_other_bp got %h want %h", b2, 32'h1234ABCD); end
    tick();
    we = 0;
    #1;
    checks++; if (a1 !== 32'h22222222) begin fails++; $display("FAIL hazard_post_nb got %h want %h", a1, 32'h22222222); end
    checks++; if (b1 !== 32'h22222222) begin fails++; $display("FAIL hazard_post_bp got %h want %h", b1, 32'h22222222); end
  endtask
  task automatic test_back_to_back();
    write(20, 32'hCAFE0001);
    write(21, 32'hCAFE0002);
    write(20, 32'hCAFE0003);
    rr1 = 20; rr2 = 21;
    #1;
    checks++; if (a1 !== 32'hCAFE0003) begin fails++; $display("FAIL b2b_nb_1 got %h want %h", a1, 32'hCAFE0003); end
    checks++; if (a2 !== 32'hCAFE0002) begin fails++; $display("FAIL b2b_nb_2 got %h want %h", a2, 32'hCAFE0002); end
    checks++; if (b1 !== 32'hCAFE0003) begin fails++; $display("FAIL b2b_bp_1 got %h want %h", b1, 32'hCAFE0003); end
  endtask
  task automatic test_reset_priority();
    logic [4:0] idx [4];
    idx = '{5'd3, 5'd10, 5'd5, 5'd7};
    reset = 1; we = 1; wr = 3; wd = 32'hA5A5A5A5; rr1 = 3; rr2 = 3;
    #1;
    checks++; if (b1 !== 32'h0) begin fails++; $display("FAIL rstpri_nobypass got %h want %h", b1, 32'h0); end
    tick();
    reset = 0; we = 0;
    for (int i = 0; i < 4; i++) begin
      rr1 = idx[i]; rr2 = idx[i];
      #1;
      checks++; if (a1 !== 32'h0) begin fails++; $display("FAIL rstpri_nb r%0d got %h want %h", idx[i], a1, 32'h0); end
      checks++; if (b2 !== 32'h0) begin fails++; $display("FAIL rstpri_bp r%0d got %h want %h", idx[i], b2, 32'h0); end
    end
  endtask
  initial begin
    test_reset();
    test_basic_write();
    test_zero_reg();
    test_write_disable();
    test_hazard();
    test_back_to_back();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
